// File: rtl/ram_device_responder.sv
// DRAM device model: decodes controller commands, tracks per-bank rows
// and tRCD, stores write bursts and replays read bursts after CL.
module ram_device_responder #(
  parameter int BANKS  = 4,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int DATA_W = 16,
  parameter int CL     = 3,
  parameter int BL     = 4,
  parameter int TRCD   = 2
) (
  input  logic                     clk_t,
  input  logic                     rst_n,
  input  logic                     cke,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [$clog2(BANKS)-1:0] ba,
  input  logic [ROW_W-1:0]         addr,
  input  logic [DATA_W-1:0]        dq_in,
  output logic [DATA_W-1:0]        dq_out,
  output logic                     dq_oe,
  output logic                     cmd_err,
  output logic [2:0]               err_code
);

  localparam int BA_W  = $clog2(BANKS);
  localparam int IDX_W = BA_W + ROW_W + COL_W;
  localparam int MEM_D = 1 << IDX_W;
  localparam int DW    = $clog2(CL);
  localparam int TW    = $clog2(TRCD + 1);
  localparam logic [COL_W-1:0] MASK = COL_W'(BL - 1);

  typedef enum logic [2:0] {
    C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_RSV
  } cmd_e;

  typedef enum logic {S_IDLE, S_ACTIVE} bank_st_e;

  cmd_e        cmd;
  logic [2:0]  rcw;
  bank_st_e    st    [BANKS];
  logic [ROW_W-1:0] row_q [BANKS];
  logic [TW-1:0]    trcd  [BANKS];
  logic        any_active;

  logic             rd_act;
  logic [DW-1:0]    rd_dly;
  logic [COL_W-1:0] rd_beat;
  logic [BA_W-1:0]  rd_ba;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_out;
  logic             rd_last;

  logic             wr_act;
  logic [COL_W-1:0] wr_beat;
  logic [BA_W-1:0]  wr_ba;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic             wr_last;
  logic             busy;

  logic [DATA_W-1:0] mem [MEM_D];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  // sequential wrap inside the BL-aligned column block
  function automatic logic [COL_W-1:0] beat_col(
    input logic [COL_W-1:0] c,
    input logic [COL_W-1:0] b
  );
    return (c & ~MASK) | ((c + b) & MASK);
  endfunction

  assign rcw = {ras_n, cas_n, we_n};

  always_comb begin
    cmd = C_NOP;
    if (cke && !cs_n) begin
      unique case (1'b1)
        rcw == 3'b111: cmd = C_NOP;
        rcw == 3'b011: cmd = C_ACT;
        rcw == 3'b101: cmd = C_RD;
        rcw == 3'b100: cmd = C_WR;
        rcw == 3'b010: cmd = C_PRE;
        rcw == 3'b001: cmd = C_REF;
        default:       cmd = C_RSV;
      endcase
    end
  end

  always_comb begin
    any_active = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (st[b] == S_ACTIVE) any_active = 1'b1;
    end
  end

  assign rd_out  = rd_act && (rd_dly == '0);
  assign rd_last = rd_out && (rd_beat == MASK);
  assign wr_last = wr_act && (wr_beat == MASK);
  // the final beat edge frees the bus for a new command
  assign busy = (rd_act && !rd_last) || (wr_act && !wr_last);

  assign rd_idx = {rd_ba, rd_row, beat_col(rd_col, rd_beat)};
  assign wr_idx = {wr_ba, wr_row, beat_col(wr_col, wr_beat)};

  always_ff @(posedge clk_t) begin
    if (wr_act) mem[wr_idx] <= dq_in;
  end

  always_ff @(posedge clk_t or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        st[b]    <= S_IDLE;
        row_q[b] <= '0;
        trcd[b]  <= '0;
      end
      rd_act   <= 1'b0;
      rd_dly   <= '0;
      rd_beat  <= '0;
      rd_ba    <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      wr_act   <= 1'b0;
      wr_beat  <= '0;
      wr_ba    <= '0;
      wr_row   <= '0;
      wr_col   <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      cmd_err  <= 1'b0;
      err_code <= '0;
    end else begin
      cmd_err <= 1'b0;
      dq_oe   <= 1'b0;
      dq_out  <= '0;
      for (int b = 0; b < BANKS; b++) begin
        if (trcd[b] != '0) trcd[b] <= trcd[b] - TW'(1);
      end
      if (rd_act) begin
        if (!rd_out) begin
          rd_dly <= rd_dly - DW'(1);
        end else begin
          dq_oe   <= 1'b1;
          dq_out  <= mem[rd_idx];
          rd_beat <= rd_beat + COL_W'(1);
          if (rd_last) rd_act <= 1'b0;
        end
      end
      if (wr_act) begin
        wr_beat <= wr_beat + COL_W'(1);
        if (wr_last) wr_act <= 1'b0;
      end
      unique case (cmd)
        C_ACT: begin
          if (st[ba] == S_ACTIVE) begin
            cmd_err  <= 1'b1;
            err_code <= 3'd1;
          end else begin
            st[ba]    <= S_ACTIVE;
            row_q[ba] <= addr;
            trcd[ba]  <= TW'(TRCD - 1);
          end
        end
        C_PRE: st[ba] <= S_IDLE;
        C_REF: begin
          if (any_active) begin
            cmd_err  <= 1'b1;
            err_code <= 3'd6;
          end
        end
        C_RD, C_WR: begin
          if (st[ba] == S_IDLE) begin
            cmd_err  <= 1'b1;
            err_code <= 3'd2;
          end else if (trcd[ba] != '0) begin
            cmd_err  <= 1'b1;
            err_code <= 3'd3;
          end else if (busy) begin
            cmd_err  <= 1'b1;
            err_code <= 3'd4;
          end else if (cmd == C_RD) begin
            rd_act  <= 1'b1;
            rd_dly  <= DW'(CL - 2);
            rd_beat <= '0;
            rd_ba   <= ba;
            rd_row  <= row_q[ba];
            rd_col  <= addr[COL_W-1:0];
          end else begin
            wr_act  <= 1'b1;
            wr_beat <= '0;
            wr_ba   <= ba;
            wr_row  <= row_q[ba];
            wr_col  <= addr[COL_W-1:0];
          end
        end
        C_RSV: begin
          cmd_err  <= 1'b1;
          err_code <= 3'd5;
        end
        default: ;
      endcase
    end
  end

endmodule
